// File: rtl/matrix_alu_pkg.sv
// rtl/matrix_alu_pkg.sv - shared op codes, FSM/MAC encodings and index helpers for the matrix ALU
package matrix_alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_KRON = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MAC_LOAD = 2'd0,
        MAC_ACC  = 2'd1,
        MAC_ADD  = 2'd2,
        MAC_SUB  = 2'd3
    } mac_mode_t;

    typedef logic [7:0] idx_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Row-major flat element index for a matrix with ncols columns.
    function automatic int elem_idx(input int r, input int c, input int ncols);
        return r * ncols + c;
    endfunction

endpackage

// File: rtl/matrix_alu_seq_if.sv
// rtl/matrix_alu_seq_if.sv - operand/result handshake bundle for matrix_alu_seq
interface matrix_alu_seq_if #(
    parameter int WORD_SIZE = 8,
    parameter int AROWS     = 2,
    parameter int ACOLS     = 2,
    parameter int BROWS     = 2,
    parameter int BCOLS     = 2
);
    localparam int OUT_W = 2 * WORD_SIZE + matrix_alu_pkg::clog2(ACOLS) + 1;
    localparam int NELEM = AROWS * ACOLS * BROWS * BCOLS;

    logic                               in_valid;
    logic                               in_ready;
    logic [1:0]                         op;
    logic [AROWS*ACOLS*WORD_SIZE-1:0]   A;
    logic [BROWS*BCOLS*WORD_SIZE-1:0]   B;
    logic                               out_valid;
    logic                               out_ready;
    logic [NELEM*OUT_W-1:0]             C;
    logic [1:0]                         out_op;
    logic                               err;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, C, out_op, err
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, C, out_op, err
    );
endinterface

// File: rtl/matrix_mac_unit.sv
// rtl/matrix_mac_unit.sv - shared multiplier/accumulator with add and sub pass modes
module matrix_mac_unit
    import matrix_alu_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int OUT_W     = 18
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_en,
    input  mac_mode_t            i_mode,
    input  logic [WORD_SIZE-1:0] i_a,
    input  logic [WORD_SIZE-1:0] i_b,
    output logic [OUT_W-1:0]     o_result
);
    logic [OUT_W-1:0]   r_acc;
    logic [OUT_W-1:0]   w_prod;
    logic [WORD_SIZE:0] w_sum;
    logic [WORD_SIZE:0] w_diff;

    always_comb begin
        w_prod   = OUT_W'(i_a) * OUT_W'(i_b);
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        w_diff   = {1'b0, i_a} - {1'b0, i_b};
        o_result = w_prod;
        case (i_mode)
            MAC_LOAD: o_result = w_prod;
            MAC_ACC:  o_result = r_acc + w_prod;
            MAC_ADD:  o_result = OUT_W'(w_sum);
            default:  o_result = {{(OUT_W-WORD_SIZE-1){w_diff[WORD_SIZE]}}, w_diff};
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_result;
        end
    end
endmodule

// File: rtl/matrix_alu_seq.sv
// rtl/matrix_alu_seq.sv - handshaked matrix add/sub/mul/Kronecker on one shared MAC, one step per cycle
module matrix_alu_seq
    import matrix_alu_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int AROWS     = 2,
    parameter int ACOLS     = 2,
    parameter int BROWS     = 2,
    parameter int BCOLS     = 2
) (
    input  logic            clk,
    input  logic            resetn,
    matrix_alu_seq_if.slave bus
);
    localparam int OUT_W     = 2 * WORD_SIZE + clog2(ACOLS) + 1;
    localparam int NELEM     = AROWS * ACOLS * BROWS * BCOLS;
    localparam int CW        = NELEM * OUT_W;
    localparam int AW        = AROWS * ACOLS * WORD_SIZE;
    localparam int BW        = BROWS * BCOLS * WORD_SIZE;
    localparam bit ADDSUB_OK = (AROWS == BROWS) && (ACOLS == BCOLS);
    localparam bit MUL_OK    = (ACOLS == BROWS);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_op;
    logic [AW-1:0]    r_a;
    logic [BW-1:0]    r_b;
    logic [CW-1:0]    r_c;
    logic             r_err;
    idx_t             r_d0, r_d1, r_d2, r_d3;

    idx_t             w_last0, w_last1, w_last2, w_last3;
    logic             w_wrap1, w_wrap2, w_wrap3, w_step_last;
    logic             w_accept, w_legal, w_write;
    mac_mode_t        w_mode;
    int               w_a_idx, w_b_idx, w_c_idx;
    logic [AW-1:0]    w_a_sh;
    logic [BW-1:0]    w_b_sh;
    logic [WORD_SIZE-1:0] w_mac_a, w_mac_b;
    logic [OUT_W-1:0] w_mac_res;
    logic [CW-1:0]    w_c_mask, w_c_next;

    assign w_accept      = (r_state == ST_IDLE) && bus.in_valid;
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.C         = r_c;
    assign bus.out_op    = r_op;
    assign bus.err       = r_err;

    always_comb begin
        w_legal = 1'b1;
        case (bus.op)
            OP_ADD, OP_SUB: w_legal = ADDSUB_OK;
            OP_MUL:         w_legal = MUL_OK;
            default:        w_legal = 1'b1;
        endcase
    end

    // Per-op loop bounds, operand/result positions and MAC mode from the counters d0 (outer) .. d3 (inner).
    always_comb begin
        w_last0 = idx_t'(AROWS - 1);
        w_last1 = idx_t'(ACOLS - 1);
        w_last2 = '0;
        w_last3 = '0;
        w_mode  = MAC_LOAD;
        w_write = 1'b1;
        w_a_idx = elem_idx(int'(r_d0), int'(r_d1), ACOLS);
        w_b_idx = elem_idx(int'(r_d0), int'(r_d1), BCOLS);
        w_c_idx = elem_idx(int'(r_d0), int'(r_d1), ACOLS);
        case (r_op)
            OP_ADD: w_mode = MAC_ADD;
            OP_SUB: w_mode = MAC_SUB;
            OP_MUL: begin
                w_last1 = idx_t'(BCOLS - 1);
                w_last2 = idx_t'(ACOLS - 1);
                w_mode  = (r_d2 == '0) ? MAC_LOAD : MAC_ACC;
                w_write = (r_d2 == w_last2);
                w_a_idx = elem_idx(int'(r_d0), int'(r_d2), ACOLS);
                w_b_idx = elem_idx(int'(r_d2), int'(r_d1), BCOLS);
                w_c_idx = elem_idx(int'(r_d0), int'(r_d1), BCOLS);
            end
            default: begin
                w_last2 = idx_t'(BROWS - 1);
                w_last3 = idx_t'(BCOLS - 1);
                w_b_idx = elem_idx(int'(r_d2), int'(r_d3), BCOLS);
                w_c_idx = elem_idx(int'(r_d0) * BROWS + int'(r_d2),
                                   int'(r_d1) * BCOLS + int'(r_d3), ACOLS * BCOLS);
            end
        endcase
    end

    always_comb begin
        w_wrap3     = (r_d3 == w_last3);
        w_wrap2     = w_wrap3 && (r_d2 == w_last2);
        w_wrap1     = w_wrap2 && (r_d1 == w_last1);
        w_step_last = w_wrap1 && (r_d0 == w_last0);
        w_a_sh      = r_a >> (w_a_idx * WORD_SIZE);
        w_b_sh      = r_b >> (w_b_idx * WORD_SIZE);
        w_mac_a     = w_a_sh[WORD_SIZE-1:0];
        w_mac_b     = w_b_sh[WORD_SIZE-1:0];
        w_c_mask    = CW'({OUT_W{1'b1}}) << (w_c_idx * OUT_W);
        w_c_next    = (r_c & ~w_c_mask) | (CW'(w_mac_res) << (w_c_idx * OUT_W));
    end

    matrix_mac_unit #(
        .WORD_SIZE (WORD_SIZE),
        .OUT_W     (OUT_W)
    ) u_mac (
        .clk      (clk),
        .resetn   (resetn),
        .i_en     (r_state == ST_COMPUTE),
        .i_mode   (w_mode),
        .i_a      (w_mac_a),
        .i_b      (w_mac_b),
        .o_result (w_mac_res)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (bus.in_valid) w_next_state = w_legal ? ST_COMPUTE : ST_DONE;
            ST_COMPUTE: if (w_step_last) w_next_state = ST_DONE;
            ST_DONE:    if (bus.out_ready) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_err <= 1'b0;
            r_d0  <= '0;
            r_d1  <= '0;
            r_d2  <= '0;
            r_d3  <= '0;
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_c   <= '0;
            r_err <= !w_legal;
            r_d0  <= '0;
            r_d1  <= '0;
            r_d2  <= '0;
            r_d3  <= '0;
        end else if (r_state == ST_COMPUTE) begin
            if (w_write) begin
                r_c <= w_c_next;
            end
            r_d3 <= w_wrap3 ? '0 : r_d3 + idx_t'(1);
            if (w_wrap3) r_d2 <= w_wrap2 ? '0 : r_d2 + idx_t'(1);
            if (w_wrap2) r_d1 <= w_wrap1 ? '0 : r_d1 + idx_t'(1);
            if (w_wrap1) r_d0 <= w_step_last ? '0 : r_d0 + idx_t'(1);
        end
    end
endmodule

// File: tb/tb_matrix_alu_seq.sv
// tb/tb_matrix_alu_seq.sv - directed vector bench for matrix_alu_seq
module tb_matrix_alu_seq;
    import matrix_alu_pkg::*;

    localparam int OUT_W = 18;
    localparam int NE    = 16;
    localparam int CW    = NE * OUT_W;

    typedef logic [CW-1:0] c_t;
    typedef int elems_t [16];
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        c_t          exp_c;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    matrix_alu_seq_if #(.WORD_SIZE(8), .AROWS(2), .ACOLS(2), .BROWS(2), .BCOLS(2)) bus ();
    matrix_alu_seq #(.WORD_SIZE(8), .AROWS(2), .ACOLS(2), .BROWS(2), .BCOLS(2)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    matrix_alu_seq_if #(.WORD_SIZE(8), .AROWS(2), .ACOLS(3), .BROWS(2), .BCOLS(2)) ebus ();
    matrix_alu_seq #(.WORD_SIZE(8), .AROWS(2), .ACOLS(3), .BROWS(2), .BCOLS(2)) edut (
        .clk(clk), .resetn(resetn), .bus(ebus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic c_t pk(input elems_t e);
        c_t r;
        logic [31:0] v;
        r = '0;
        for (int i = 0; i < NE; i++) begin
            v = e[i];
            r = r | (c_t'(v[OUT_W-1:0]) << (i * OUT_W));
        end
        return r;
    endfunction

    function automatic c_t pk4(input int e0, input int e1, input int e2, input int e3);
        elems_t e;
        e = '{default: 0};
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        e[3] = e3;
        return pk(e);
    endfunction

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output c_t c, output logic e, output logic [1:0] oop);
        int guard;
        bus.op = op;
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        c = bus.C;
        e = bus.err;
        oop = bus.out_op;
        tick();
    endtask

    initial begin
        vec_t        vt [7];
        elems_t      ek;
        int          lat;
        c_t          c;
        c_t          c0;
        logic        er;
        logic [1:0]  oo;
        logic [1:0]  eops [2];

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = 2'b00;
        bus.A = '0;
        bus.B = '0;
        ebus.in_valid = 1'b0;
        ebus.out_ready = 1'b1;
        ebus.op = 2'b00;
        ebus.A = '0;
        ebus.B = '0;
        resetn = 1'b0;
        tick();
        tick();
        check("reset_state", {bus.in_ready, bus.out_valid, bus.err, bus.out_op, bus.C},
              {1'b1, 1'b0, 1'b0, 2'b00, c_t'(0)});
        resetn = 1'b1;
        tick();

        ek = '{5, 6, 10, 12, 7, 8, 14, 16, 15, 18, 20, 24, 21, 24, 28, 32};
        vt[0] = '{OP_ADD,  32'h04030201, 32'h08070605, pk4(6, 8, 10, 12), 5};
        vt[1] = '{OP_SUB,  32'h04030201, 32'h08070605, pk4('h3FFFC, 'h3FFFC, 'h3FFFC, 'h3FFFC), 5};
        vt[2] = '{OP_MUL,  32'h04030201, 32'h08070605, pk4(19, 22, 43, 50), 9};
        vt[3] = '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, pk4(130050, 130050, 130050, 130050), 9};
        vt[4] = '{OP_KRON, 32'h04030201, 32'h08070605, pk(ek), 17};
        vt[5] = '{OP_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, pk4(510, 510, 510, 510), 5};
        vt[6] = '{OP_SUB,  32'h00000000, 32'hFFFFFFFF, pk4('h3FF01, 'h3FF01, 'h3FF01, 'h3FF01), 5};

        for (int i = 0; i < 7; i++) begin
            run(vt[i].op, vt[i].a, vt[i].b, lat, c, er, oo);
            check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
            check($sformatf("v%0d_C", i), c, vt[i].exp_c);
            check($sformatf("v%0d_err_op", i), {er, oo}, {1'b0, vt[i].op});
        end

        // Backpressure: result held in DONE while a second bundle waits.
        bus.op = OP_ADD;
        bus.A = 32'h04030201;
        bus.B = 32'h08070605;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.op = OP_MUL;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        c0 = bus.C;
        check("bp_first_C", c0, vt[0].exp_c);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i), {bus.out_valid, bus.in_ready, bus.err, bus.out_op, bus.C},
                  {1'b1, 1'b0, 1'b0, OP_ADD, vt[0].exp_c});
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);
        tick();
        bus.in_valid = 1'b0;
        check("bp_second_accept", bus.in_ready, 1'b0);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("bp_second_latency", lat, 9);
        check("bp_second_C", {bus.out_op, bus.C}, {OP_MUL, vt[2].exp_c});
        tick();

        // Reset in the middle of a multiply.
        bus.op = OP_MUL;
        bus.A = 32'h04030201;
        bus.B = 32'h08070605;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        check("rst_mid_partial", {bus.out_valid, bus.C[OUT_W-1:0]}, {1'b0, 18'd19});
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_abort", {bus.in_ready, bus.out_valid, bus.C}, {1'b1, 1'b0, c_t'(0)});
        tick();
        resetn = 1'b1;
        tick();
        run(vt[0].op, vt[0].a, vt[0].b, lat, c, er, oo);
        check("rst_recover_C", c, vt[0].exp_c);
        check("rst_recover_latency", lat, 5);

        // Dimension errors on the 2x3 / 2x2 instance.
        eops[0] = OP_MUL;
        eops[1] = OP_ADD;
        for (int i = 0; i < 2; i++) begin
            ebus.op = eops[i];
            ebus.A = 48'h060504030201;
            ebus.B = 32'h08070605;
            ebus.in_valid = 1'b1;
            check($sformatf("e%0d_ready", i), ebus.in_ready, 1'b1);
            tick();
            ebus.in_valid = 1'b0;
            check($sformatf("e%0d_result", i), {ebus.out_valid, ebus.err, ebus.out_op, ebus.C},
                  {1'b1, 1'b1, eops[i], 456'd0});
            tick();
            check($sformatf("e%0d_drop", i), {ebus.out_valid, ebus.in_ready}, 2'b01);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
